// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared types and default widths for the CNN MAC datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  // Default widths of the Booth-product accumulation path
  localparam int DEF_KERNEL_SIZE = 9;
  localparam int DEF_PROD_W      = 16;
  localparam int DEF_ACC_W       = 20;

  // Window accumulation controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2,
    OUT   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/relu_sat_quant.sv
`default_nettype none
// ============================================================================
// Module      : relu_sat_quant
// Description : Round-half-up arithmetic shift, ReLU and saturation of a
//               signed accumulator down to an unsigned 7-bit pixel value.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_sat_quant #(
  parameter int ACC_W = 20,
  parameter int SHIFT = 4
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [7:0]       q
);

  // One guard bit so the rounding add can never wrap
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'(127);

  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] rounded;
  logic signed [ACC_W:0] shifted;

  assign acc_ext = {acc[ACC_W-1], acc};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);
      assign rounded = acc_ext + HALF;
    end else begin : g_no_round
      assign rounded = acc_ext;
    end
  endgenerate

  assign shifted = rounded >>> SHIFT;

  // Clamp negatives to zero and large positives to 127
  always_comb begin
    q = 8'd0;
    if (shifted[ACC_W]) begin
      q = 8'd0;
    end else if (shifted > SAT_MAX) begin
      q = 8'd127;
    end else begin
      q = {1'b0, shifted[6:0]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_mac_accum.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac_accum
// Description : Accumulates KERNEL_SIZE signed products plus a bias into one
//               output pixel, quantises it and hands it off over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac_accum
  import cnn_pkg::*;
#(
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int PROD_W      = DEF_PROD_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int SHIFT       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic signed [PROD_W-1:0] bias,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [7:0]        out_data,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic        [7:0]        beat_cnt
);

  // The bias is one extra summand, so the window holds KERNEL_SIZE+1 terms.
  generate
    if (ACC_W < PROD_W + $clog2(KERNEL_SIZE + 1)) begin : g_bad_acc_w
      $error("conv_mac_accum: ACC_W too narrow for KERNEL_SIZE products plus bias");
    end
    if (KERNEL_SIZE < 1 || KERNEL_SIZE > 255) begin : g_bad_kernel
      $error("conv_mac_accum: KERNEL_SIZE must be 1..255");
    end
    if (SHIFT < 0 || SHIFT > ACC_W - 2) begin : g_bad_shift
      $error("conv_mac_accum: SHIFT must be 0..ACC_W-2");
    end
  endgenerate

  localparam logic [7:0] LAST_BEAT = 8'(KERNEL_SIZE - 1);

  state_t                 state;
  state_t                 state_next;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] prod_ext;
  logic        [7:0]       quant;
  logic                    accept;
  logic                    abort;

  assign bias_ext = {{(ACC_W-PROD_W){bias[PROD_W-1]}}, bias};
  assign prod_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
  assign in_ready = (state == IDLE) || (state == ACCUM);
  assign accept   = in_valid && in_ready;
  // A pending result in OUT must finish its handshake before clear can act
  assign abort    = clear && (state != OUT);

  relu_sat_quant #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_quant (
    .acc (acc),
    .q   (quant)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (accept) begin
          state_next = (KERNEL_SIZE == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (abort) begin
          state_next = IDLE;
        end else if (accept && (beat_cnt == LAST_BEAT)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = abort ? IDLE : OUT;
      end
      OUT: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator, beat counter and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_acc   <= '0;
    end else if (abort) begin
      acc       <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc      <= bias_ext + prod_ext;
            beat_cnt <= 8'd1;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc      <= acc + prod_ext;
            beat_cnt <= beat_cnt + 8'd1;
          end
        end
        DONE: begin
          out_acc   <= acc;
          out_data  <= quant;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            beat_cnt  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_mac_accum
// Description : Directed self-checking bench for conv_mac_accum.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_mac_accum;

  logic               clk;
  logic               rst_n;
  logic               clear;
  logic signed [15:0] bias;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] product;
  logic               out_valid;
  logic               out_ready;
  logic        [7:0]  out_data;
  logic signed [19:0] out_acc;
  logic        [7:0]  beat_cnt;

  int n_assert;
  int n_fail;

  conv_mac_accum #(
    .KERNEL_SIZE (9),
    .PROD_W      (16),
    .ACC_W       (20),
    .SHIFT       (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_acc   (out_acc),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Nine beats of the same product; bias is scrambled after the first beat
  task automatic feed(input logic signed [15:0] b, input logic signed [15:0] p,
                      input int gap);
    for (int i = 0; i < 9; i++) begin
      bias     = b;
      product  = p;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      bias     = 16'sh7F00;
      if (i < 8) repeat (gap) tick();
    end
  endtask

  // Called in DONE (the cycle after the last accept)
  task automatic expect_result(input string tag, input int exp_acc, input int exp_data);
    check({tag, "_done_valid"}, 32'(out_valid), 0);
    check({tag, "_done_ready"}, 32'(in_ready), 0);
    check({tag, "_done_cnt"}, 32'(beat_cnt), 9);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_acc"}, 32'(out_acc), exp_acc);
    check({tag, "_data"}, 32'(out_data), exp_data);
    if (out_ready) begin
      tick();
      check({tag, "_pulse_end"}, 32'(out_valid), 0);
      check({tag, "_idle_ready"}, 32'(in_ready), 1);
      check({tag, "_idle_cnt"}, 32'(beat_cnt), 0);
    end
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    product   = '0;
    out_ready = 1'b1;

    #12;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_data", 32'(out_data), 0);
    check("rst_acc", 32'(out_acc), 0);
    check("rst_cnt", 32'(beat_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Basic: 9 x 100 -> 900, (900+8)>>4 = 56
    feed(16'sd0, 16'sd100, 0);
    expect_result("basic", 900, 56);

    // ReLU: -50 + 9 x -1000 = -9050 -> 0
    feed(-16'sd50, -16'sd1000, 0);
    expect_result("relu", -9050, 0);

    // Saturation
    feed(16'sd0, 16'sd16384, 0);
    expect_result("sat", 147456, 127);
    feed(16'sd32767, 16'sd16384, 0);
    expect_result("sat_bias", 180223, 127);

    // Rounding boundaries around 127 and 0
    feed(16'sd2023, 16'sd0, 0);
    expect_result("rnd_126", 2023, 126);
    feed(16'sd2024, 16'sd0, 0);
    expect_result("rnd_127", 2024, 127);
    feed(16'sd7, 16'sd0, 0);
    expect_result("rnd_down", 7, 0);
    feed(16'sd8, 16'sd0, 0);
    expect_result("rnd_up", 8, 1);
    feed(-16'sd8, 16'sd0, 0);
    expect_result("rnd_neg", -8, 0);

    // Bubbles between beats: 20 + 9 x 37 = 353 -> (361)>>4 = 22
    feed(16'sd20, 16'sd37, 2);
    expect_result("bubble", 353, 22);

    // Back-pressure: hold out_ready low for 5 cycles while in_valid is offered
    out_ready = 1'b0;
    feed(16'sd0, 16'sd16384, 0);
    expect_result("stall", 147456, 127);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      product  = 16'sd1;
      tick();
      check("stall_ready", 32'(in_ready), 0);
      check("stall_valid", 32'(out_valid), 1);
      check("stall_data", 32'(out_data), 127);
      check("stall_cnt", 32'(beat_cnt), 9);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall_release", 32'(out_valid), 0);
    check("stall_idle_cnt", 32'(beat_cnt), 0);

    // Clear after 4 beats; the beat offered with clear is discarded
    bias     = 16'sd500;
    product  = 16'sd77;
    in_valid = 1'b1;
    repeat (4) tick();
    check("clr_cnt4", 32'(beat_cnt), 4);
    product = 16'sd999;
    clear   = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clr_cnt0", 32'(beat_cnt), 0);
    check("clr_ready", 32'(in_ready), 1);
    feed(16'sd6, 16'sd10, 0);
    expect_result("after_clr", 96, 6);

    // Clear during OUT must not drop the pending result
    out_ready = 1'b0;
    feed(16'sd0, 16'sd100, 0);
    expect_result("clr_out", 900, 56);
    clear = 1'b1;
    repeat (2) tick();
    clear = 1'b0;
    check("clr_out_valid", 32'(out_valid), 1);
    check("clr_out_data", 32'(out_data), 56);
    out_ready = 1'b1;
    tick();
    check("clr_out_done", 32'(out_valid), 0);

    // Async reset mid-window
    bias     = 16'sd3;
    product  = 16'sd50;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    check("arst_pre_cnt", 32'(beat_cnt), 3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_win_cnt", 32'(beat_cnt), 0);
    check("arst_win_acc", 32'(out_acc), 0);
    check("arst_win_data", 32'(out_data), 0);
    #2 rst_n = 1'b1;
    tick();

    // Async reset while the result is waiting
    out_ready = 1'b0;
    feed(16'sd0, 16'sd100, 0);
    expect_result("arst_out", 900, 56);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_data", 32'(out_data), 0);
    check("arst_out_acc", 32'(out_acc), 0);
    check("arst_out_ready", 32'(in_ready), 1);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Full window after reset: -100 + 9 x 250 = 2150 -> 127
    feed(-16'sd100, 16'sd250, 1);
    expect_result("post_rst", 2150, 127);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
